reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin write arbiter/sequencer for the shared 4-bit latch-based register
//  (D-latch bank, level-sensitive enable). Up to NREQ requesters post write data;
//  the arbiter grants one at a time, drives the register enable/data with a safe
//  enable pulse plus a hold cycle, then acknowledges the winner.
// PARAMETERS
//  NREQ        4  number of requesters (2..8)
//  WIDTH       4  register data width
//  HOLD_CYCLES 1  cycles reg_en is held high per write (1..15)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req        in   NREQ        write request per requester, level
//  req_data   in   NREQ*WIDTH  write data; requester i at [i*WIDTH +: WIDTH]
//  gnt        out  NREQ        one-hot grant, high from LOAD through SETTLE
//  ack        out  NREQ        one-hot, 1-cycle pulse: write complete
//  reg_en     out  1           enable to the register latches
//  reg_d      out  WIDTH       data to the register latches
//  busy       out  1           high in any state except IDLE
//  owner      out  3           index of last granted requester
//  wr_count   out  8           completed writes, wraps 255->0
// BEHAVIOUR
//  - All outputs registered. Reset (async): state=IDLE, gnt=0, ack=0, reg_en=0,
//    reg_d=0, busy=0, owner=0, wr_count=0, rr pointer ptr=0. Reset mid-write
//    drops reg_en in the same instant; no ack issued for the aborted write.
//  - FSM: IDLE -> LOAD -> SETTLE -> ACK -> IDLE.
//  - IDLE: on an edge with req!=0, pick g = first set req bit searching
//    ptr, ptr+1, ... mod NREQ; capture req_data[g] into reg_d; gnt[g]=1,
//    reg_en=1, owner=g, busy=1, go LOAD. req==0: stay IDLE.
//  - LOAD: reg_en high for exactly HOLD_CYCLES cycles (internal down-counter),
//    then reg_en=0, go SETTLE. reg_d held; req/req_data changes ignored.
//  - SETTLE: 1 cycle, reg_en=0, reg_d still held (latch hold time); then
//    gnt=0, ack[g]=1, wr_count+=1 (mod 256), ptr=(g+1) mod NREQ, go ACK.
//  - ACK: 1 cycle; then ack=0, busy=0, go IDLE. IDLE always lasts >=1 cycle
//    before next arbitration.
//  - Latency: req sampled at edge k -> reg_en high after edges k..k+H-1
//    (H=HOLD_CYCLES), ack high after edge k+H+1, earliest next grant at edge
//    k+H+3. Min write period H+3 cycles.
//  - Requester rule: hold req and req_data until ack seen; drop req on the edge
//    after ack. Arbiter does not re-sample the winner before that edge.
//  - Withdrawn req after grant: write still completes and is acked.
//  - reg_d changes only on IDLE->LOAD; never while reg_en=1.
//  - Simultaneous requests: strict rotation from ptr; no requester starves
//    (worst wait (NREQ-1) transactions).
//  - gnt, ack one-hot or zero at all times; never both set for same index.
// TESTING
//  1 Reset: assert rst mid-LOAD -> reg_en, gnt, busy, wr_count go 0 at once;
//    after release, IDLE, no ack pulse.
//  2 Single write: req=0001, data0=4'b1010, H=1 -> reg_en 1 cycle with
//    reg_d=1010, ack=0001 two cycles after grant, wr_count=1.
//  3 Rotation: req=1111 held (each drops after its ack) -> grant order 0,1,2,3,
//    reg_d follows each data, then ptr wraps to 0; period 4 cycles each.
//  4 Data stability: change req_data0 1010->0101 during LOAD/SETTLE ->
//    reg_d stays 1010 until next IDLE->LOAD.
//  5 HOLD_CYCLES=3: single write -> reg_en high exactly 3 cycles, ack at
//    edge k+4, next grant no earlier than edge k+6.
//  6 Counter wrap: 256 back-to-back writes -> wr_count 255 then 0; ptr
//    fairness intact (each of 4 requesters granted 64 times).

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_write_arbiter_if
//  Purpose  : Bundle of requester-side and register-side signals of the
//             round-robin write arbiter for the shared latch register.
//  Modports : master - requester/observer side (drives req, req_data)
//             slave  - arbiter side (drives grant, ack, latch and status)
//  Signals  : req[NREQ]            write request per requester, level
//             req_data[NREQ*WIDTH] write data, requester i at [i*WIDTH +: WIDTH]
//             gnt[NREQ]            one-hot grant, LOAD through SETTLE
//             ack[NREQ]            one-hot 1-cycle write-complete pulse
//             reg_en               latch enable
//             reg_d[WIDTH]         latch data
//             busy                 arbiter not idle
//             owner[3]             index of last granted requester
//             wr_count[8]          completed writes, wrapping
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  reg_en;
    logic [WIDTH-1:0]      reg_d;
    logic                  busy;
    logic [2:0]            owner;
    logic [7:0]            wr_count;

    modport master (
        output req, req_data,
        input  gnt, ack, reg_en, reg_d, busy, owner, wr_count
    );

    modport slave (
        input  req, req_data,
        output gnt, ack, reg_en, reg_d, busy, owner, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_write_arbiter
//  Purpose  : Round-robin write arbiter/sequencer for a shared latch-based
//             register. Grants one requester at a time, drives a clean
//             enable pulse of HOLD_CYCLES cycles, holds data for one settle
//             cycle with the enable low, then pulses ack to the winner.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - reg_write_arbiter_if.slave (req/req_data in; gnt, ack,
//                    reg_en, reg_d, busy, owner, wr_count out)
//  Params   : NREQ (2..8), WIDTH, HOLD_CYCLES (1..15)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_write_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic             r_reg_en;
    logic [WIDTH-1:0] r_reg_d;
    logic             r_busy;
    logic [2:0]       r_owner;
    logic [7:0]       r_wr_count;
    logic [2:0]       r_ptr;
    logic [3:0]       r_cnt;

    logic [7:0]       w_req_ext;
    logic             w_found;
    logic [2:0]       w_sel;
    logic [3:0]       w_idx;
    logic [NREQ-1:0]  w_sel_oh;
    logic [WIDTH-1:0] w_data;
    logic [2:0]       w_ptr_next;

    // Zero-extend so any 3-bit index is in range regardless of NREQ.
    assign w_req_ext = 8'(bus.req);
    assign w_found   = |bus.req;

    // Rotating priority search. Walking offsets from high to low means the
    // smallest offset from r_ptr is written last and therefore wins.
    always_comb begin
        w_sel = 3'd0;
        w_idx = 4'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + 4'(i);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (w_req_ext[w_idx[2:0]]) begin
                w_sel = w_idx[2:0];
            end
        end
    end

    // One-hot grant vector and data mux for the selected requester.
    always_comb begin
        w_sel_oh = '0;
        w_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == 3'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_data      = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_reg_en   <= 1'b0;
            r_reg_d    <= '0;
            r_busy     <= 1'b0;
            r_owner    <= 3'd0;
            r_wr_count <= 8'd0;
            r_ptr      <= 3'd0;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // reg_d is only ever loaded here, while reg_en is low.
                    if (w_found) begin
                        r_gnt    <= w_sel_oh;
                        r_reg_en <= 1'b1;
                        r_reg_d  <= w_data;
                        r_owner  <= w_sel;
                        r_busy   <= 1'b1;
                        r_cnt    <= 4'(HOLD_CYCLES - 1);
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == 4'd0) begin
                        r_reg_en <= 1'b0;
                        r_state  <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SETTLE: begin
                    // Data stays on reg_d one more cycle for latch hold time.
                    r_gnt      <= '0;
                    r_ack      <= r_gnt;
                    r_wr_count <= r_wr_count + 8'd1;
                    r_ptr      <= w_ptr_next;
                    r_state    <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.reg_en   = r_reg_en;
    assign bus.reg_d    = r_reg_d;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_write_arbiter
//  Purpose  : Self-checking bench for reg_write_arbiter. Instance A uses
//             HOLD_CYCLES=1, instance B uses HOLD_CYCLES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NREQ(4), .WIDTH(4)) ia ();
    reg_write_arbiter_if #(.NREQ(4), .WIDTH(4)) ib ();

    reg_write_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(1)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia)
    );

    reg_write_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(3)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        int          exp_g;
        logic [3:0]  exp_d;
    } vec_t;

    vec_t       vecs [10];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_wr = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete write on instance A, starting with A idle.
    task automatic a_write(input logic [3:0] rq, input logic [15:0] dat,
                           input int g, input logic [3:0] d,
                           input logic [15:0] dat_after);
        int cyc;
        @(negedge clk);
        ia.req      = rq;
        ia.req_data = dat;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (ia.gnt == 4'd0 && cyc < 10);
        chk("grant_lat", cyc, 1);
        chk("gnt", 32'(ia.gnt), 32'd1 << g);
        chk("reg_en_on", 32'(ia.reg_en), 1);
        chk("reg_d", 32'(ia.reg_d), 32'(d));
        chk("owner", 32'(ia.owner), g);
        chk("busy", 32'(ia.busy), 1);
        ia.req_data = dat_after;
        @(posedge clk); #1;
        chk("reg_en_off", 32'(ia.reg_en), 0);
        chk("gnt_settle", 32'(ia.gnt), 32'd1 << g);
        chk("reg_d_hold", 32'(ia.reg_d), 32'(d));
        chk("ack_early", 32'(ia.ack), 0);
        @(posedge clk); #1;
        exp_wr = exp_wr + 8'd1;
        chk("ack", 32'(ia.ack), 32'd1 << g);
        chk("gnt_clear", 32'(ia.gnt), 0);
        chk("wr_count", 32'(ia.wr_count), 32'(exp_wr));
        ia.req = 4'd0;
        @(posedge clk); #1;
        chk("ack_pulse", 32'(ia.ack), 0);
        chk("busy_idle", 32'(ia.busy), 0);
    endtask

    initial begin
        // Expected values follow the rotation pointer by hand, starting at 0.
        vecs[0] = '{4'b0001, 16'h000A, 0, 4'hA};
        vecs[1] = '{4'b0001, 16'h0005, 0, 4'h5};
        vecs[2] = '{4'b1001, 16'h3007, 3, 4'h3};
        vecs[3] = '{4'b1001, 16'h3007, 0, 4'h7};
        vecs[4] = '{4'b0110, 16'h0CB0, 1, 4'hB};
        vecs[5] = '{4'b0110, 16'h0CB0, 2, 4'hC};
        vecs[6] = '{4'b0110, 16'h0CB0, 1, 4'hB};
        vecs[7] = '{4'b1000, 16'hF000, 3, 4'hF};
        vecs[8] = '{4'b1110, 16'h9870, 1, 4'h7};
        vecs[9] = '{4'b1100, 16'h9870, 2, 4'h8};

        ia.req = 4'd0; ia.req_data = 16'd0;
        ib.req = 4'd0; ib.req_data = 16'd0;

        // ---------------- power-on reset state
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", 32'(ia.gnt), 0);
        chk("rst_ack", 32'(ia.ack), 0);
        chk("rst_reg_en", 32'(ia.reg_en), 0);
        chk("rst_reg_d", 32'(ia.reg_d), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_owner", 32'(ia.owner), 0);
        chk("rst_wr_count", 32'(ia.wr_count), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---------------- HOLD_CYCLES=3 timing on instance B
        begin
            logic [3:0] e_en  [7];
            logic [3:0] e_gnt [7];
            logic [3:0] e_ack [7];
            e_en  = '{1, 1, 1, 0, 0, 0, 1};
            e_gnt = '{2, 2, 2, 2, 0, 0, 2};
            e_ack = '{0, 0, 0, 0, 2, 0, 0};
            @(negedge clk);
            ib.req      = 4'b0010;
            ib.req_data = 16'h00D0;
            for (int c = 0; c < 7; c++) begin
                @(posedge clk); #1;
                chk("h3_reg_en", 32'(ib.reg_en), 32'(e_en[c]));
                chk("h3_gnt", 32'(ib.gnt), 32'(e_gnt[c]));
                chk("h3_ack", 32'(ib.ack), 32'(e_ack[c]));
            end
            chk("h3_reg_d", 32'(ib.reg_d), 32'hD);
            chk("h3_wr_count", 32'(ib.wr_count), 1);
        end

        // ---------------- asynchronous reset in the middle of LOAD on B
        begin
            int bad;
            #3;
            rst_b = 1'b1;
            #1;
            chk("arst_reg_en", 32'(ib.reg_en), 0);
            chk("arst_gnt", 32'(ib.gnt), 0);
            chk("arst_busy", 32'(ib.busy), 0);
            chk("arst_wr_count", 32'(ib.wr_count), 0);
            ib.req = 4'd0;
            @(negedge clk);
            rst_b = 1'b0;
            bad = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (ib.ack != 4'd0 || ib.busy || ib.reg_en) bad++;
            end
            chk("arst_no_ack", bad, 0);
        end

        // ---------------- table-driven single writes on A
        for (int i = 0; i < 10; i++) begin
            a_write(vecs[i].req, vecs[i].data, vecs[i].exp_g, vecs[i].exp_d, vecs[i].data);
        end

        // ---------------- data change during LOAD/SETTLE is ignored
        a_write(4'b0001, 16'h000A, 0, 4'hA, 16'h0005);
        a_write(4'b0001, 16'h0005, 0, 4'h5, 16'h0005);

        // ---------------- idle reset of A to restart rotation at 0
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("rst2_wr_count", 32'(ia.wr_count), 0);
        @(negedge clk);
        rst_a = 1'b0;
        exp_wr = 8'd0;

        // ---------------- rotation with all four requesting
        begin
            int         n;
            int         last;
            logic [3:0] prev;
            n = 0; last = 0; prev = 4'd0;
            @(negedge clk);
            ia.req      = 4'b1111;
            ia.req_data = 16'h4321;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk); #1;
                if (ia.gnt != 4'd0 && prev == 4'd0) begin
                    if (n < 4) begin
                        chk("rot_gnt", 32'(ia.gnt), 32'd1 << n);
                        chk("rot_reg_d", 32'(ia.reg_d), n + 1);
                        if (n > 0) chk("rot_period", c - last, 4);
                    end
                    last = c;
                    n++;
                end
                if (ia.ack != 4'd0) ia.req = ia.req & ~ia.ack;
                prev = ia.gnt;
            end
            chk("rot_grants", n, 4);
            chk("rot_wr_count", 32'(ia.wr_count), 4);
            exp_wr = 8'd4;
        end

        // ---------------- 256 back-to-back writes: wrap and fairness
        begin
            int         acks;
            int         cnt [4];
            int         wc_err;
            int         oh_err;
            int         saw_wrap;
            logic [3:0] first_ack;
            logic [7:0] prev_wc;
            acks = 0; wc_err = 0; oh_err = 0; saw_wrap = 0;
            first_ack = 4'd0;
            cnt = '{0, 0, 0, 0};
            prev_wc = ia.wr_count;
            @(negedge clk);
            ia.req      = 4'b1111;
            ia.req_data = 16'h8642;
            for (int c = 0; c < 1100 && acks < 256; c++) begin
                @(posedge clk); #1;
                if (!$onehot0(ia.gnt) || !$onehot0(ia.ack) || (ia.gnt & ia.ack) != 4'd0)
                    oh_err++;
                if (ia.ack != 4'd0) begin
                    if (acks == 0) first_ack = ia.ack;
                    acks++;
                    exp_wr = exp_wr + 8'd1;
                    if (ia.wr_count !== exp_wr) wc_err++;
                    if (prev_wc == 8'd255 && ia.wr_count == 8'd0) saw_wrap = 1;
                    for (int k = 0; k < 4; k++) if (ia.ack[k]) cnt[k]++;
                end
                prev_wc = ia.wr_count;
            end
            ia.req = 4'd0;
            chk("wrap_acks", acks, 256);
            chk("wrap_first_ack", 32'(first_ack), 1);
            for (int k = 0; k < 4; k++) chk("wrap_fair", cnt[k], 64);
            chk("wrap_count_seq", wc_err, 0);
            chk("wrap_255_to_0", saw_wrap, 1);
            chk("wrap_onehot", oh_err, 0);
            chk("wrap_final", 32'(ia.wr_count), 4);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
